// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin single-owner arbiter with rotating priority
// Optional forced release of a stuck owner is built when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int MAX_HOLD = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout_err
);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_param_check
    $error("rr_grant_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, nxt_ptr;
  logic             busy_q, busy_d;
  logic             rel, frc;
  logic [IDX_W:0]   pick_idle, pick_hand;

  // Returns {found, index} of the first set bit scanning start, start+1, ... modulo N_REQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0] res;
    int c;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      c = int'(start) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (r[IDX_W'(c)]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  always_comb begin
    nxt_ptr = idx_q + 1'b1;
    if (int'(idx_q) == N_REQ - 1) nxt_ptr = '0;
  end

  assign rel       = done[idx_q] | ~req[idx_q];
  assign pick_idle = rr_pick(req, ptr_q);
  // The releasing owner is masked so it cannot be handed the grant straight back.
  assign pick_hand = rr_pick(req & ~(N_REQ'(1) << idx_q), nxt_ptr);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[IDX_W]) begin
          state_d = OWNED;
          idx_d   = pick_idle[IDX_W-1:0];
          grant_d = N_REQ'(1) << pick_idle[IDX_W-1:0];
          busy_d  = 1'b1;
        end
      end
      OWNED: begin
        if (rel | frc) begin
          ptr_d = nxt_ptr;
          if (pick_hand[IDX_W]) begin
            idx_d   = pick_hand[IDX_W-1:0];
            grant_d = N_REQ'(1) << pick_hand[IDX_W-1:0];
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              terr_q;
  logic              new_grant;

  // Counter value MAX_HOLD-1 means the owner has already held for MAX_HOLD cycles.
  assign frc       = ~rel & (state_q == OWNED) & (hold_q >= HOLD_W'(MAX_HOLD - 1));
  assign new_grant = (state_d == OWNED) & ((state_q == IDLE) | rel | frc);

  always_comb begin
    hold_d = hold_q;
    if (new_grant) hold_d = '0;
    else if (state_q == OWNED && hold_q < HOLD_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      terr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      terr_q <= frc;
    end
  end

  assign timeout_err = terr_q;
`else
  assign frc         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed and randomized bench for rr_grant_arbiter
module tb_rr_grant_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference: owner number (-1 when idle), pointer, last owner, cycles the grant has been visible.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_held  = 0;
  bit m_terr  = 1'b0;

  function automatic int find(input logic [N-1:0] r, input int start, input int excl);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (start + i) % N;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int o, nown, nptr, nlast, nheld;
    bit rel, frc, nterr;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_last  <= 0;
      m_held  <= 0;
      m_terr  <= 1'b0;
    end else begin
      nown = m_owner; nptr = m_ptr; nlast = m_last; nheld = m_held; nterr = 1'b0;
      if (m_owner < 0) begin
        o = find(req, m_ptr, -1);
        if (o >= 0) begin nown = o; nlast = o; nheld = 1; end
      end else begin
        rel = done[m_owner] || !req[m_owner];
        frc = TMO && !rel && (m_held >= MH);
        if (rel || frc) begin
          nptr = (m_owner + 1) % N;
          o    = find(req, nptr, m_owner);
          nown = o;
          if (o >= 0) begin nlast = o; nheld = 1; end
        end else begin
          nheld = m_held + 1;
        end
        nterr = frc;
      end
      m_owner <= nown;
      m_ptr   <= nptr;
      m_last  <= nlast;
      m_held  <= nheld;
      m_terr  <= nterr;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    checks++;
    if (grant !== eg || grant_idx !== 2'(m_last) || busy !== (m_owner >= 0) ||
        timeout_err !== m_terr) begin
      errors++;
      $display("FAIL model t=%0t grant=%b exp=%b idx=%0d exp=%0d busy=%b exp=%b terr=%b exp=%b",
               $time, grant, eg, grant_idx, m_last, busy, (m_owner >= 0), timeout_err, m_terr);
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r;
    done = d;
    @(posedge clk);
    #2;
  endtask

  logic [N-1:0] exp_g;
  logic         exp_t;

  initial begin
    #12;
    lit("reset_grant", 8'(grant), 8'h0);
    lit("reset_idx", 8'(grant_idx), 8'h0);
    lit("reset_busy", 8'(busy), 8'h0);
    lit("reset_terr", 8'(timeout_err), 8'h0);
    #5 rst_n = 1'b1;

    cyc(4'b0100, 4'b0000);
    lit("single_grant", 8'(grant), 8'h4);
    lit("single_idx", 8'(grant_idx), 8'h2);
    lit("single_busy", 8'(busy), 8'h1);
    cyc(4'b0000, 4'b0100);
    lit("single_release", 8'(grant), 8'h0);
    lit("single_idle_busy", 8'(busy), 8'h0);
    lit("idle_idx_holds", 8'(grant_idx), 8'h2);

    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc(4'b1111, 4'b0000);
    lit("rot_first", 8'(grant), 8'h1);
    for (int k = 1; k <= 4; k++) begin
      cyc(4'b1111, N'(1 << ((k - 1) % N)));
      lit("rot_order", 8'(grant), 8'(1 << (k % N)));
      lit("rot_busy", 8'(busy), 8'h1);
    end

    cyc(4'b0000, 4'b0000);
    cyc(4'b0010, 4'b0000);
    lit("own1", 8'(grant), 8'h2);
    cyc(4'b1010, 4'b1001);
    lit("foreign_done", 8'(grant), 8'h2);
    cyc(4'b1000, 4'b0000);
    lit("req_drop_next", 8'(grant), 8'h8);
    lit("req_drop_idx", 8'(grant_idx), 8'h3);
    cyc(4'b1001, 4'b1000);
    lit("wrap_grant", 8'(grant), 8'h1);
    lit("wrap_idx", 8'(grant_idx), 8'h0);
    cyc(4'b0000, 4'b0000);

    cyc(4'b0100, 4'b0000);
    lit("pre_reset_grant", 8'(grant), 8'h4);
    #1 rst_n = 1'b0;
    #1;
    lit("async_grant", 8'(grant), 8'h0);
    lit("async_busy", 8'(busy), 8'h0);
    req = 4'b0110;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    lit("post_reset_grant", 8'(grant), 8'h2);
    lit("post_reset_idx", 8'(grant_idx), 8'h1);

    cyc(4'b0000, 4'b0000);
    cyc(4'b0011, 4'b0000);
    lit("hold_start", 8'(grant), 8'h1);
    for (int i = 1; i < MH; i++) begin
      cyc(4'b0011, 4'b0000);
      lit("hold_keep", 8'(grant), 8'h1);
      lit("hold_terr", 8'(timeout_err), 8'h0);
    end
`ifdef ARB_TIMEOUT_EN
    exp_g = 4'b0010;
    exp_t = 1'b1;
`else
    exp_g = 4'b0001;
    exp_t = 1'b0;
`endif
    cyc(4'b0011, 4'b0000);
    lit("timeout_grant", 8'(grant), 8'(exp_g));
    lit("timeout_pulse", 8'(timeout_err), 8'(exp_t));
    cyc(4'b0011, 4'b0000);
    lit("timeout_after", 8'(grant), 8'(exp_g));
    lit("timeout_clear", 8'(timeout_err), 8'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] r, d;
      r = req;
      d = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(99) < 20) r[b] = ~r[b];
        if ($urandom_range(99) < 15) d[b] = 1'b1;
      end
      if (n % 97 == 50) r = '1;
      cyc(r, d);
      if (n == 1500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    lit("final_idle", 8'(busy), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
